// File: rtl/adpll_phase_error_detector.sv
// rtl/adpll_phase_error_detector.sv - counter-based ADPLL frequency/phase error detector
module adpll_phase_error_detector #(
  parameter int ERROR_WIDTH = 5,
  parameter int CNT_WIDTH   = 8,
  parameter int LOCK_TOL    = 1,
  parameter int LOCK_COUNT  = 16
) (
  input  logic                   gen_clk_i,
  input  logic                   reset_n_i,
  input  logic                   enable_i,
  input  logic                   ref_i,
  input  logic                   dco_i,
  input  logic [CNT_WIDTH-1:0]   div_n_i,
  output logic [ERROR_WIDTH-1:0] error_o,
  output logic                   error_valid_o,
  output logic                   lock_o
);

  // Error saturation limits and lock tolerance at the (CNT_WIDTH+1)-bit signed width of e.
  // ERROR_WIDTH is assumed not to exceed CNT_WIDTH+1.
  localparam int EMAX  = 2**(ERROR_WIDTH-1) - 1;
  localparam int EMIN  = -(2**(ERROR_WIDTH-1));
  localparam int RUN_W = $clog2(LOCK_COUNT + 1);
  localparam logic signed [CNT_WIDTH:0] E_MAX   = signed'((CNT_WIDTH+1)'(EMAX));
  localparam logic signed [CNT_WIDTH:0] E_MIN   = signed'((CNT_WIDTH+1)'(EMIN));
  localparam logic signed [CNT_WIDTH:0] TOL_POS = signed'((CNT_WIDTH+1)'(LOCK_TOL));
  localparam logic signed [CNT_WIDTH:0] TOL_NEG = signed'((CNT_WIDTH+1)'(-LOCK_TOL));
  localparam logic [RUN_W-1:0]          RUN_MAX = RUN_W'(LOCK_COUNT);

  typedef enum logic [1:0] {IDLE, ARMED, COUNT} state_e;

  state_e                 state_q, state_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic [ERROR_WIDTH-1:0] err_q, err_d;
  logic                   valid_q, valid_d;
  logic                   lock_q, lock_d;
  logic [RUN_W-1:0]       run_q, run_d;

  logic ref_s1_q, ref_s2_q, ref_d_q, ref_rise_q;
  logic dco_s1_q, dco_s2_q, dco_d_q, dco_rise_q;

  logic [CNT_WIDTH-1:0]        cnt_inc, cnt_close;
  logic signed [CNT_WIDTH:0]   e_full;
  logic [ERROR_WIDTH-1:0]      err_sat;
  logic                        in_tol;
  logic [RUN_W-1:0]            run_inc;

  // Synchronise ref/dco and register a one-cycle rising-edge pulse for each.
  // Both paths share identical latency so window edges stay aligned.
  always_ff @(posedge gen_clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      ref_s1_q   <= 1'b0;
      ref_s2_q   <= 1'b0;
      ref_d_q    <= 1'b0;
      ref_rise_q <= 1'b0;
      dco_s1_q   <= 1'b0;
      dco_s2_q   <= 1'b0;
      dco_d_q    <= 1'b0;
      dco_rise_q <= 1'b0;
    end else begin
      ref_s1_q   <= ref_i;
      ref_s2_q   <= ref_s1_q;
      ref_d_q    <= ref_s2_q;
      ref_rise_q <= ref_s2_q & ~ref_d_q;
      dco_s1_q   <= dco_i;
      dco_s2_q   <= dco_s1_q;
      dco_d_q    <= dco_s2_q;
      dco_rise_q <= dco_s2_q & ~dco_d_q;
    end
  end

  // Window arithmetic: a DCO edge coincident with the closing ref edge belongs to
  // the closing window; e is then saturated into the loop filter's error range.
  always_comb begin
    cnt_inc   = (cnt_q == {CNT_WIDTH{1'b1}}) ? cnt_q : cnt_q + 1'b1;
    cnt_close = dco_rise_q ? cnt_inc : cnt_q;
    e_full    = $signed({1'b0, div_n_i}) - $signed({1'b0, cnt_close});
    if (e_full > E_MAX) begin
      err_sat = E_MAX[ERROR_WIDTH-1:0];
    end else if (e_full < E_MIN) begin
      err_sat = E_MIN[ERROR_WIDTH-1:0];
    end else begin
      err_sat = e_full[ERROR_WIDTH-1:0];
    end
    in_tol  = (e_full <= TOL_POS) && (e_full >= TOL_NEG);
    run_inc = (run_q == RUN_MAX) ? run_q : run_q + 1'b1;
  end

  // State and datapath registers.
  always_ff @(posedge gen_clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      err_q   <= '0;
      valid_q <= 1'b0;
      lock_q  <= 1'b0;
      run_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      valid_q <= valid_d;
      lock_q  <= lock_d;
      run_q   <= run_d;
    end
  end

  // Next-state logic: arm on enable, discard the first partial window, then
  // close a window and emit an error on every synchronised ref edge.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    valid_d = 1'b0;
    lock_d  = lock_q;
    run_d   = run_q;
    if (!enable_i) begin
      state_d = IDLE;
      cnt_d   = '0;
      err_d   = '0;
      lock_d  = 1'b0;
      run_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_d   = '0;
          state_d = ARMED;
        end
        ARMED: begin
          if (ref_rise_q) begin
            cnt_d   = '0;
            state_d = COUNT;
          end
        end
        COUNT: begin
          if (ref_rise_q) begin
            err_d   = err_sat;
            valid_d = 1'b1;
            cnt_d   = '0;
            if (in_tol) begin
              run_d  = run_inc;
              lock_d = (run_inc == RUN_MAX);
            end else begin
              run_d  = '0;
              lock_d = 1'b0;
            end
          end else if (dco_rise_q) begin
            cnt_d = cnt_inc;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign error_o       = err_q;
  assign error_valid_o = valid_q;
  assign lock_o        = lock_q;

endmodule

// File: doc/adpll_phase_error_detector.md
# adpll_phase_error_detector

Counter-based frequency/phase error detector for the ADPLL: it produces the signed error word that the PI loop filter consumes. It samples the reference clock and the DCO output in the `gen_clk_i` domain and counts DCO rising edges in each reference period. It compares that count with the programmed divide ratio and emits a saturated signed error with a one-cycle valid strobe. It also flags lock after a run of in-tolerance windows.

## Interface
- `ERROR_WIDTH`, default 5: signed error output width; matches the loop filter's error input.
- `CNT_WIDTH`, default 8: DCO edge counter width; also the width of `div_n_i`.
- `LOCK_TOL`, default 1: maximum |error| for a window to count as in-tolerance.
- `LOCK_COUNT`, default 16: number of consecutive in-tolerance windows required to assert lock.

Ports:
- `gen_clk_i`, in, 1: system clock; the only clock.
- `reset_n_i`, in, 1: asynchronous, active-low reset.
- `enable_i`, in, 1: detector enable; low forces IDLE.
- `ref_i`, in, 1: reference clock, asynchronous to `gen_clk_i`.
- `dco_i`, in, 1: DCO output, asynchronous; its frequency is < `gen_clk_i`/2.
- `div_n_i`, in, CNT_WIDTH: expected DCO edges per reference period (unsigned).
- `error_o`, out, ERROR_WIDTH: signed error; positive means the DCO is slow.
- `error_valid_o`, out, 1: one-cycle strobe when `error_o` updates.
- `lock_o`, out, 1: lock indicator.

## Operation
- Synchronisers:
  - `ref_i` and `dco_i` each pass through a 2-flop synchroniser, then an edge-detect flop.
  - This yields internal one-cycle pulses `ref_rise` and `dco_rise`.
- FSM has three states:
  - IDLE: counter cleared. Goes to ARMED when `enable_i` is high.
  - ARMED: waits for the first `ref_rise`. On it, clears the counter and goes to COUNT. No error is emitted for this edge (partial window discarded).
  - COUNT: each `dco_rise` increments the counter. The counter saturates at 2^CNT_WIDTH−1 and does not wrap.
  - On `ref_rise` in COUNT, the window closes: compute the error, pulse valid, restart the counter, and stay in COUNT.
  - Any state with `enable_i` low goes to IDLE on the next edge.
- Simultaneous `ref_rise` and `dco_rise`: the DCO edge is counted in the closing window. The new window starts at count 0.
- Error arithmetic:
  - At window close, `div_n_i` is sampled.
  - e = `div_n_i` − count, computed at CNT_WIDTH+1 bits signed.
  - e is saturated to [−2^(ERROR_WIDTH−1), 2^(ERROR_WIDTH−1)−1], then registered into `error_o`.
- `error_o` holds its value between strobes.
- Disable behaviour: on entry to IDLE from disable, `error_o` is cleared to 0 and `lock_o` is cleared.
- Lock:
  - A saturating run counter counts consecutive windows with |e| ≤ LOCK_TOL, where e is the pre-saturation value.
  - `lock_o` is set in the same cycle as the valid strobe that completes LOCK_COUNT windows.
  - Any out-of-tolerance window clears the run counter and `lock_o` with its own strobe.
- Reset values (asynchronous, while `reset_n_i`=0):
  - `error_o`=0, `error_valid_o`=0, `lock_o`=0.
  - State IDLE; counter, run counter and synchroniser flops all 0.
- Reset mid-window: the partial count is discarded. After release, the detector passes through ARMED again, so the first strobe comes two reference edges later.

## Timing
- `ref_i` sampled high at gen_clk edge k gives `ref_rise` during cycle k+2. `error_o` and `error_valid_o` update at edge k+3.
- `error_valid_o` is high for exactly one cycle per completed window.
- The minimum window length is 4 gen_clk cycles. Reference pulses closer together than this are not required to be resolved.
- `dco_i` edges are counted with the same 2-cycle synchroniser latency, so the window alignment of ref and DCO edges is consistent.
- `lock_o` changes only on `error_valid_o` cycles, or when going to IDLE / reset.

## Test plan
- Reset: hold `reset_n_i`=0 with ref/dco toggling -> `error_o`=0, `error_valid_o`=0, `lock_o`=0. Release with `enable_i`=1 -> no strobe on the first ref edge; first strobe on the second.
- Nominal: `div_n_i`=10, exactly 10 DCO edges per ref period -> `error_o`=0 with a one-cycle strobe every period, 3 cycles after ref is sampled high.
- Offset and saturation: 8 edges/window -> `error_o`=+2. 30 edges/window -> −20, saturated to −16 (`ERROR_WIDTH`=5).
- Missing reference: ref held low for more than 300 DCO edges, then one edge -> counter stops at 255; `error_o`=−16; no wrap.
- Lock: 16 windows with errors alternating +1/−1 -> `lock_o` rises with the 16th strobe. Then one window of 7 edges -> `error_o`=+3 and `lock_o` falls on that strobe.
- Disable/reset mid-window: drop `enable_i` for 1 cycle mid-window -> `error_o`=0 and `lock_o`=0; next strobe only after two more ref edges. Repeat using `reset_n_i` -> identical behaviour.
